// File: rtl/unpadding.sv
// +----------------------------------------------------------------------+
// | unpadding : crops the PADDING-wide border ring off a padded frame     |
// |             stream and flags non-zero border pixels.                  |
// | Revision  : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module unpadding #(
  parameter int N       = 8,
  parameter int CHANNEL = 3,
  parameter int SIZE    = 32,
  parameter int PADDING = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 input_vld,
  input  logic [CHANNEL*N-1:0] input_din,
  output logic [CHANNEL*N-1:0] crop_dout,
  output logic                 crop_dout_vld,
  output logic                 crop_dout_end,
  output logic                 border_err
);

  localparam int W  = SIZE + 2 * PADDING;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int DW = CHANNEL * N;

  localparam logic [CW-1:0] LAST = CW'(W - 1);
  localparam logic [31:0]   LO   = 32'(PADDING);
  localparam logic [31:0]   HI   = 32'(PADDING + SIZE);

  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          vld_q, vld_d;
  logic          end_q, end_d;
  logic          err_q, err_d;

  logic [31:0]   row_ext;
  logic [31:0]   col_ext;
  logic          inner;
  logic          first;
  logic          last;
  logic          border_hit;

  always_comb begin
    row_ext    = 32'(row_q);
    col_ext    = 32'(col_q);
    inner      = (row_ext >= LO) && (row_ext < HI) &&
                 (col_ext >= LO) && (col_ext < HI);
    first      = (row_q == '0) && (col_q == '0);
    last       = (row_q == LAST) && (col_q == LAST);
    border_hit = !inner && (|input_din);

    col_d  = col_q;
    row_d  = row_q;
    dout_d = dout_q;
    vld_d  = 1'b0;
    end_d  = end_q;
    err_d  = err_q;

    if (input_vld) begin
      vld_d = inner;
      if (inner) begin
        dout_d = input_din;
      end

      // Frame start clears stale error status; a faulty beat 0 re-arms it.
      if (first) begin
        end_d = 1'b0;
        err_d = border_hit;
      end else if (border_hit) begin
        err_d = 1'b1;
      end

      // For a 1x1 frame start and end coincide and end must win.
      if (last) begin
        end_d = 1'b1;
      end

      if (col_q == LAST) begin
        col_d = '0;
        row_d = last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q  <= '0;
      row_q  <= '0;
      dout_q <= '0;
      vld_q  <= 1'b0;
      end_q  <= 1'b1;
      err_q  <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      dout_q <= dout_d;
      vld_q  <= vld_d;
      end_q  <= end_d;
      err_q  <= err_d;
    end
  end

  assign crop_dout     = dout_q;
  assign crop_dout_vld = vld_q;
  assign crop_dout_end = end_q;
  assign border_err    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_unpadding.sv
// +----------------------------------------------------------------------+
// | tb_unpadding : randomized self-checking bench for unpadding          |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_unpadding;

  localparam int N     = 8;
  localparam int CH    = 3;
  localparam int S     = 4;
  localparam int P     = 1;
  localparam int W     = S + 2 * P;
  localparam int BEATS = W * W;
  localparam int DW    = CH * N;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          input_vld;
  logic [DW-1:0] input_din;
  logic [DW-1:0] crop_dout;
  logic          crop_dout_vld;
  logic          crop_dout_end;
  logic          border_err;

  unpadding #(.N(N), .CHANNEL(CH), .SIZE(S), .PADDING(P)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .input_vld     (input_vld),
    .input_din     (input_din),
    .crop_dout     (crop_dout),
    .crop_dout_vld (crop_dout_vld),
    .crop_dout_end (crop_dout_end),
    .border_err    (border_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Expected-state model, derived from the beat's position in the frame
  int            m_idx;
  logic [DW-1:0] exp_dout;
  logic          exp_vld;
  logic          exp_end;
  logic          exp_err;

  logic [DW-1:0] frame [BEATS];
  logic [DW-1:0] orig  [S*S];
  logic [DW-1:0] got_q [$];
  int            exp_list [S*S] = '{7, 8, 9, 10, 13, 14, 15, 16,
                                    19, 20, 21, 22, 25, 26, 27, 28};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_inner(input int idx);
    int r, c;
    r = idx / W;
    c = idx % W;
    return (r >= P) && (r < P + S) && (c >= P) && (c < P + S);
  endfunction

  task automatic model_update(input logic v, input logic [DW-1:0] d);
    bit inn;
    if (!rst_n) begin
      m_idx = 0; exp_dout = '0; exp_vld = 1'b0; exp_end = 1'b1; exp_err = 1'b0;
    end else if (v) begin
      inn     = is_inner(m_idx);
      exp_vld = inn;
      if (inn) exp_dout = d;
      if (m_idx == 0) begin
        exp_end = 1'b0;
        exp_err = !inn && (d != 0);
      end else if (!inn && (d != 0)) begin
        exp_err = 1'b1;
      end
      if (m_idx == BEATS - 1) exp_end = 1'b1;
      m_idx = (m_idx + 1) % BEATS;
    end else begin
      exp_vld = 1'b0;
    end
  endtask

  task automatic step(input logic v, input logic [DW-1:0] d);
    input_vld = v;
    input_din = d;
    @(posedge clk);
    model_update(v, d);
    #1;
    check("dout", 32'(crop_dout), 32'(exp_dout));
    check("vld",  32'(crop_dout_vld), 32'(exp_vld));
    check("end",  32'(crop_dout_end), 32'(exp_end));
    check("err",  32'(border_err), 32'(exp_err));
    if (crop_dout_vld) got_q.push_back(crop_dout);
  endtask

  // gap: 0 = contiguous, 2 = two idle cycles between beats, -1 = random gaps
  task automatic send_frame(input int gap);
    for (int i = 0; i < BEATS; i++) begin
      step(1'b1, frame[i]);
      if (gap > 0) begin
        repeat (gap) step(1'b0, DW'($urandom));
      end else if (gap < 0) begin
        repeat ($urandom_range(0, 2)) step(1'b0, DW'($urandom));
      end
    end
  endtask

  task automatic fill_index();
    for (int i = 0; i < BEATS; i++) frame[i] = is_inner(i) ? DW'(i) : '0;
  endtask

  // Behavioural zero-padding stage feeding the loopback test
  task automatic fill_loop();
    int k;
    for (int i = 0; i < S * S; i++) orig[i] = DW'($urandom);
    k = 0;
    for (int r = 0; r < W; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r >= P && r < P + S && c >= P && c < P + S) begin
          frame[r*W + c] = orig[k];
          k++;
        end else begin
          frame[r*W + c] = '0;
        end
      end
    end
  endtask

  task automatic check_index_list(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(S * S));
    for (int i = 0; i < S * S; i++) begin
      if (i < got_q.size()) check(tag, 32'(got_q[i]), 32'(exp_list[i]));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    input_vld = 1'b0;
    input_din = '0;
    repeat (3) step(1'b0, '0);
    check("rst_end", 32'(crop_dout_end), 32'd1);
    check("rst_vld", 32'(crop_dout_vld), 32'd0);
    rst_n = 1'b1;

    // Contiguous index frame
    fill_index();
    got_q.delete();
    send_frame(0);
    step(1'b0, '0);
    check_index_list("seq_contig");
    check("contig_err", 32'(border_err), 32'd0);

    // Valid every third cycle
    got_q.delete();
    send_frame(2);
    step(1'b0, '0);
    check_index_list("seq_gap3");

    // Faulty border on beat 0, then a clean frame clears it
    fill_index();
    frame[0] = 24'h0000FF;
    got_q.delete();
    step(1'b1, frame[0]);
    check("err_after_beat0", 32'(border_err), 32'd1);
    for (int i = 1; i < BEATS; i++) step(1'b1, frame[i]);
    check("err_frame_end", 32'(border_err), 32'd1);
    check_index_list("seq_err");
    fill_index();
    step(1'b1, frame[0]);
    check("err_cleared", 32'(border_err), 32'd0);
    for (int i = 1; i < BEATS; i++) step(1'b1, frame[i]);
    step(1'b0, '0);

    // Back-to-back frames
    got_q.delete();
    send_frame(0);
    check("b2b_end_between", 32'(crop_dout_end), 32'd1);
    send_frame(0);
    check("b2b_count", 32'(got_q.size()), 32'(2 * S * S));
    step(1'b0, '0);

    // Reset mid-frame, then a full frame
    for (int i = 0; i < 20; i++) step(1'b1, frame[i]);
    rst_n = 1'b0;
    repeat (3) step(1'b1, DW'($urandom));
    rst_n = 1'b1;
    got_q.delete();
    send_frame(0);
    check_index_list("seq_after_rst");

    // Loopback through a behavioural padding stage, random gaps
    for (int f = 0; f < 4; f++) begin
      fill_loop();
      got_q.delete();
      send_frame(-1);
      check("loop_count", 32'(got_q.size()), 32'(S * S));
      for (int i = 0; i < S * S; i++) begin
        if (i < got_q.size()) check("loop_pix", 32'(got_q[i]), 32'(orig[i]));
      end
      check("loop_err", 32'(border_err), 32'd0);
    end

    // Random frames with occasional border faults anywhere in the ring
    for (int f = 0; f < 6; f++) begin
      fill_loop();
      for (int i = 0; i < BEATS; i++) begin
        if (!is_inner(i) && ($urandom_range(0, 29) == 0)) frame[i] = DW'($urandom_range(1, 255));
      end
      send_frame(-1);
    end
    step(1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/unpadding.md
Name: unpadding

Overview:
- Inverse of the zero-padding stage in the CNN datapath.
- Consumes a padded feature-map stream of (SIZE+2*PADDING)^2 beats, row-major, one pixel (all channels) per valid beat.
- Discards the border ring and emits the inner SIZE x SIZE pixels in order.
- Used to crop conv/pool outputs back to nominal size, and as a loopback checker for the padding stage: it flags any non-zero border pixel.

Parameters:
- N, 8, bit width of one channel sample
- CHANNEL, 3, channels packed per beat
- SIZE, 32, inner (output) feature-map width = height
- PADDING, 1, border width removed on each side; must satisfy PADDING >= 0

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- input_vld  input  1  input beat valid; no backpressure
- input_din  input  CHANNEL*N  padded pixel, channel 0 in LSBs
- crop_dout  output  CHANNEL*N  cropped pixel, registered
- crop_dout_vld  output  1  crop_dout valid, one-cycle per pixel
- crop_dout_end  output  1  level: 1 = idle/frame complete, 0 = frame in progress
- border_err  output  1  sticky per frame: some border beat of the current/last frame was non-zero

Behaviour:
- Reset is synchronous, active-low on rst_n, clock clk. All state is updated on posedge clk only.
- Reset values: crop_dout=0, crop_dout_vld=0, crop_dout_end=1, border_err=0, col=0, row=0.
- W = SIZE+2*PADDING. Counters col and row each span 0..W-1, width clog2(W) (minimum 1).
- Counters advance only on input_vld=1. Cycles with input_vld=0 change no counter and force crop_dout_vld=0.
- Per accepted beat, define inner = (row >= PADDING) && (row < PADDING+SIZE) && (col >= PADDING) && (col < PADDING+SIZE).
- inner beat: next cycle crop_dout <= input_din and crop_dout_vld <= 1. Latency is exactly 1 cycle.
- border beat: crop_dout holds its previous value and crop_dout_vld <= 0. If input_din != 0, border_err <= 1.
- Counter advance:
  - col < W-1: col++.
  - col == W-1: col <= 0 and row++.
  - (row, col) == (W-1, W-1): both counters wrap to 0, ready for the next frame with no idle cycle required.
- Frame start is beat (0,0):
  - crop_dout_end <= 0.
  - border_err <= (input_din != 0 && beat is border). This clears stale status from the previous frame; with PADDING=0 it clears to 0.
- Frame end is beat (W-1, W-1): crop_dout_end <= 1 in the following cycle.
- W == 1: the start and end rules fire on the same beat; end wins, so crop_dout_end stays 1.
- Exactly SIZE*SIZE crop_dout_vld pulses occur per frame, in row-major order.
- PADDING=0: block is a 1-cycle registered pass-through and border_err stays 0.
- No input_vld gap constraint. Back-to-back frames are supported: crop_dout_end is 1 for exactly one cycle between them.
- Reset mid-frame: a partial frame is abandoned with no further outputs. The next valid beat is treated as (0,0).

Test Plan:
- SIZE=4, PADDING=1 (W=6); 36 consecutive beats, din = beat index on inner beats, 0 on border beats -> 16 vld pulses carrying 7,8,9,10,13,14,15,16,19,20,21,22,25,26,27,28, each 1 cycle after its input beat; crop_dout_end falls after beat 0, rises 1 cycle after beat 35; border_err=0.
- Same frame with input_vld asserted every 3rd cycle -> identical output sequence; each vld exactly 1 cycle after its beat; crop_dout holds between pulses.
- Beat 0 = 0x0000FF, all other border beats 0 -> border_err=1 from the cycle after beat 0 through frame end; data outputs unchanged. A following clean frame clears border_err on its beat 0.
- Two back-to-back frames with no gap -> 32 vld pulses; crop_dout_end high for exactly one cycle between frames.
- Reset asserted after 20 beats, then a full 36-beat frame -> all outputs at reset values during reset; no stale outputs; new frame yields exactly 16 correct pixels.
- Loopback: padding stage (SIZE=4, PADDING=1) driving this block with a random 16-pixel frame -> output equals the original 16 pixels in order; border_err=0.
